// File: rtl/hline_sched_pkg.sv
// hline_sched_pkg: shared types and address arithmetic for the span scheduler
package hline_sched_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ISSUE, WAIT} state_t;
  localparam int ADDR_W = 32;
  localparam int STRIDE_LOG2_DEF = 12;
  function automatic logic [ADDR_W-1:0] row_addr(input logic [ADDR_W-1:0] base, input logic [15:0] y,
                                                 input logic [15:0] x, input int sl2);
    return base + (ADDR_W'(y) << sl2) + (ADDR_W'(x) << 2);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant, searching upward from ptr with wrap
module rr_arbiter #(
  parameter int N = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) gnt = N'(1) << ((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/hline_span_sched.sv
// hline_span_sched: arbitrates span commands, normalizes them and drives the hline_zbuff engine
module hline_span_sched
  import hline_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int STRIDE_LOG2 = STRIDE_LOG2_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [31:0]        fb_base,
  input  logic [31:0]        zbuff_base,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_y,
  input  logic [16*NREQ-1:0] req_x1,
  input  logic [16*NREQ-1:0] req_x2,
  input  logic [32*NREQ-1:0] req_z1,
  input  logic [32*NREQ-1:0] req_z2,
  input  logic [32*NREQ-1:0] req_slope,
  output logic               eng_start,
  output logic [31:0]        eng_fb_addr,
  output logic [31:0]        eng_zbuff_addr,
  output logic [31:0]        eng_y,
  output logic [15:0]        eng_x1,
  output logic [15:0]        eng_x2,
  output logic [31:0]        eng_z1,
  output logic [31:0]        eng_z2,
  output logic [31:0]        eng_slope,
  input  logic               eng_done,
  output logic               busy,
  output logic               err_timeout,
  output logic [15:0]        span_count
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [PW-1:0] rr_ptr, win;
  logic [NREQ-1:0] gnt;
  logic [WW-1:0] wd;
  logic [15:0] cy, cx1, cx2, x_lo;
  logic [31:0] cz1, cz2, cs;
  logic swap;
  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (.req(req_valid), .ptr(rr_ptr), .gnt(gnt));
  always_comb begin
    win = '0;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) win = PW'(i);
  end
  assign cy = req_y[int'(win)*16 +: 16];
  assign cx1 = req_x1[int'(win)*16 +: 16];
  assign cx2 = req_x2[int'(win)*16 +: 16];
  assign cz1 = req_z1[int'(win)*32 +: 32];
  assign cz2 = req_z2[int'(win)*32 +: 32];
  assign cs = req_slope[int'(win)*32 +: 32];
  assign swap = cx1 > cx2;
  assign x_lo = swap ? cx2 : cx1;
  assign req_ready = (state == GRANT) ? gnt : '0;
  assign eng_start = state == ISSUE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      rr_ptr <= '0;
      wd <= '0;
      err_timeout <= 1'b0;
      span_count <= '0;
      eng_fb_addr <= '0;
      eng_zbuff_addr <= '0;
      eng_y <= '0;
      eng_x1 <= '0;
      eng_x2 <= '0;
      eng_z1 <= '0;
      eng_z2 <= '0;
      eng_slope <= '0;
    end else begin
      case (state)
        IDLE: state <= (|req_valid) ? GRANT : IDLE;
        GRANT: begin
          // a requester may withdraw between IDLE and GRANT; then nothing is granted
          if (|gnt) begin
            rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            state <= (cx1 == cx2) ? IDLE : ISSUE;
            if (cx1 != cx2) begin
              eng_x1 <= x_lo;
              eng_x2 <= swap ? cx1 : cx2;
              eng_z1 <= swap ? cz2 : cz1;
              eng_z2 <= swap ? cz1 : cz2;
              eng_slope <= swap ? -cs : cs;
              eng_y <= {16'd0, cy};
              eng_fb_addr <= row_addr(fb_base, cy, x_lo, STRIDE_LOG2);
              eng_zbuff_addr <= row_addr(zbuff_base, cy, x_lo, STRIDE_LOG2);
            end
          end else state <= IDLE;
        end
        ISSUE: begin
          state <= WAIT;
          span_count <= span_count + 1'b1;
          wd <= WW'(1);
        end
        WAIT: begin
          // wd counts cycles since eng_start, so the abort lands TIMEOUT edges after it
          if (eng_done) state <= (|req_valid) ? GRANT : IDLE;
          else if (wd == WW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state <= IDLE;
          end else wd <= wd + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hline_span_sched.sv
// tb_hline_span_sched: directed self-checking bench for the span scheduler
module tb_hline_span_sched;
  localparam int NREQ = 2;
  logic clk = 1'b0, nreset = 1'b0;
  logic [31:0] fb_base, zbuff_base;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [16*NREQ-1:0] req_y, req_x1, req_x2;
  logic [32*NREQ-1:0] req_z1, req_z2, req_slope;
  logic eng_start, eng_done, busy, err_timeout;
  logic [31:0] eng_fb_addr, eng_zbuff_addr, eng_y, eng_z1, eng_z2, eng_slope;
  logic [15:0] eng_x1, eng_x2, span_count;
  int cmp = 0, bad = 0;

  hline_span_sched #(.NREQ(NREQ), .STRIDE_LOG2(12), .TIMEOUT(16)) dut (
    .clk(clk), .nreset(nreset), .fb_base(fb_base), .zbuff_base(zbuff_base),
    .req_valid(req_valid), .req_ready(req_ready), .req_y(req_y), .req_x1(req_x1), .req_x2(req_x2),
    .req_z1(req_z1), .req_z2(req_z2), .req_slope(req_slope), .eng_start(eng_start),
    .eng_fb_addr(eng_fb_addr), .eng_zbuff_addr(eng_zbuff_addr), .eng_y(eng_y), .eng_x1(eng_x1),
    .eng_x2(eng_x2), .eng_z1(eng_z1), .eng_z2(eng_z2), .eng_slope(eng_slope), .eng_done(eng_done),
    .busy(busy), .err_timeout(err_timeout), .span_count(span_count));

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_cmd(input int r, input logic [15:0] y, x1, x2, input logic [31:0] z1, z2, s);
    req_y[r*16 +: 16] = y;
    req_x1[r*16 +: 16] = x1;
    req_x2[r*16 +: 16] = x2;
    req_z1[r*32 +: 32] = z1;
    req_z2[r*32 +: 32] = z2;
    req_slope[r*32 +: 32] = s;
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    tick;
    while (req_ready === '0 && n < 10) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    tick;
    cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    cmp++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got %b want 00", req_ready); end
    cmp++; if (eng_start !== 1'b0 || err_timeout !== 1'b0) begin bad++; $display("FAIL reset_flags got start=%b err=%b want 0 0", eng_start, err_timeout); end
    cmp++; if (span_count !== 16'd0 || eng_fb_addr !== 32'd0) begin bad++; $display("FAIL reset_regs got cnt=%0d fb=%h want 0 0", span_count, eng_fb_addr); end
    nreset = 1'b1;
    tick;
  endtask

  task automatic test_single;
    set_cmd(0, 16'd3, 16'd10, 16'd20, 32'd5, 32'd15, 32'd1);
    req_valid = 2'b01;
    tick;
    cmp++; if (req_ready !== 2'b01 || busy !== 1'b1 || eng_start !== 1'b0) begin bad++; $display("FAIL single_grant got rdy=%b busy=%b start=%b want 01 1 0", req_ready, busy, eng_start); end
    tick;
    req_valid = 2'b00;
    cmp++; if (eng_start !== 1'b1 || req_ready !== 2'b00) begin bad++; $display("FAIL single_start got start=%b rdy=%b want 1 00", eng_start, req_ready); end
    cmp++; if (eng_fb_addr !== 32'h1000_3028 || eng_zbuff_addr !== 32'h2000_3028) begin bad++; $display("FAIL single_addr got fb=%h zb=%h want 10003028 20003028", eng_fb_addr, eng_zbuff_addr); end
    cmp++; if (eng_y !== 32'd3 || eng_x1 !== 16'd10 || eng_x2 !== 16'd20) begin bad++; $display("FAIL single_params got y=%0d x1=%0d x2=%0d want 3 10 20", eng_y, eng_x1, eng_x2); end
    tick;
    cmp++; if (eng_start !== 1'b0 || busy !== 1'b1 || span_count !== 16'd1) begin bad++; $display("FAIL single_wait got start=%b busy=%b cnt=%0d want 0 1 1", eng_start, busy, span_count); end
    tick;
    cmp++; if (busy !== 1'b1 || eng_fb_addr !== 32'h1000_3028) begin bad++; $display("FAIL single_hold got busy=%b fb=%h want 1 10003028", busy, eng_fb_addr); end
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL single_done got busy=%b want 0", busy); end
  endtask

  task automatic test_reversed;
    set_cmd(1, 16'd5, 16'd50, 16'd40, 32'd100, 32'd200, 32'hFFFF_FFF6);
    req_valid = 2'b10;
    wait_ready;
    cmp++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rev_grant got %b want 10", req_ready); end
    tick;
    req_valid = 2'b00;
    cmp++; if (eng_start !== 1'b1 || eng_x1 !== 16'd40 || eng_x2 !== 16'd50) begin bad++; $display("FAIL rev_x got start=%b x1=%0d x2=%0d want 1 40 50", eng_start, eng_x1, eng_x2); end
    cmp++; if (eng_z1 !== 32'd200 || eng_z2 !== 32'd100 || eng_slope !== 32'd10) begin bad++; $display("FAIL rev_z got z1=%0d z2=%0d s=%h want 200 100 0000000a", eng_z1, eng_z2, eng_slope); end
    cmp++; if (eng_fb_addr !== 32'h1000_50A0) begin bad++; $display("FAIL rev_addr got %h want 100050a0", eng_fb_addr); end
    tick;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    cmp++; if (span_count !== 16'd2 || busy !== 1'b0) begin bad++; $display("FAIL rev_done got cnt=%0d busy=%b want 2 0", span_count, busy); end
  endtask

  task automatic test_zero_length;
    logic seen;
    seen = 1'b0;
    set_cmd(1, 16'd9, 16'd7, 16'd7, 32'd1, 32'd1, 32'd0);
    req_valid = 2'b10;
    wait_ready;
    cmp++; if (req_ready !== 2'b10) begin bad++; $display("FAIL zero_ready got %b want 10", req_ready); end
    tick;
    req_valid = 2'b00;
    cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_idle got busy=%b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      seen = seen | eng_start;
      tick;
    end
    cmp++; if (seen !== 1'b0 || span_count !== 16'd2) begin bad++; $display("FAIL zero_noissue got start_seen=%b cnt=%0d want 0 2", seen, span_count); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp;
    set_cmd(0, 16'd1, 16'd0, 16'd4, 32'd0, 32'd4, 32'd1);
    set_cmd(1, 16'd2, 16'd0, 16'd4, 32'd0, 32'd4, 32'd1);
    req_valid = 2'b11;
    wait_ready;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 1) ? 2'b10 : 2'b01;
      cmp++; if (req_ready !== exp) begin bad++; $display("FAIL b2b_grant%0d got %b want %b", k, req_ready, exp); end
      tick;
      cmp++; if (eng_start !== 1'b1 || eng_y !== 32'(k % 2 + 1)) begin bad++; $display("FAIL b2b_issue%0d got start=%b y=%0d want 1 %0d", k, eng_start, eng_y, k % 2 + 1); end
      tick;
      eng_done = 1'b1;
      if (k == 3) req_valid = 2'b00;
      tick;
      eng_done = 1'b0;
    end
    cmp++; if (busy !== 1'b0 || span_count !== 16'd6) begin bad++; $display("FAIL b2b_end got busy=%b cnt=%0d want 0 6", busy, span_count); end
  endtask

  task automatic test_timeout;
    set_cmd(0, 16'd4, 16'd1, 16'd2, 32'd0, 32'd0, 32'd0);
    req_valid = 2'b01;
    wait_ready;
    tick;
    req_valid = 2'b00;
    cmp++; if (eng_start !== 1'b1) begin bad++; $display("FAIL to_start got %b want 1", eng_start); end
    for (int i = 0; i < 15; i++) tick;
    cmp++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL to_early got err=%b busy=%b want 0 1", err_timeout, busy); end
    tick;
    cmp++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL to_fire got err=%b busy=%b want 1 0", err_timeout, busy); end
    set_cmd(1, 16'd6, 16'd3, 16'd8, 32'd0, 32'd0, 32'd0);
    req_valid = 2'b10;
    wait_ready;
    cmp++; if (req_ready !== 2'b10) begin bad++; $display("FAIL to_next_grant got %b want 10", req_ready); end
    tick;
    req_valid = 2'b00;
    cmp++; if (eng_start !== 1'b1 || eng_y !== 32'd6) begin bad++; $display("FAIL to_next_issue got start=%b y=%0d want 1 6", eng_start, eng_y); end
    tick;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    cmp++; if (span_count !== 16'd8 || err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got cnt=%0d err=%b want 8 1", span_count, err_timeout); end
  endtask

  task automatic test_reset_wait;
    set_cmd(1, 16'd7, 16'd2, 16'd9, 32'd0, 32'd0, 32'd0);
    req_valid = 2'b10;
    wait_ready;
    tick;
    req_valid = 2'b00;
    tick;
    #2 nreset = 1'b0;
    #1;
    cmp++; if (busy !== 1'b0 || err_timeout !== 1'b0 || span_count !== 16'd0) begin bad++; $display("FAIL rstw_flags got busy=%b err=%b cnt=%0d want 0 0 0", busy, err_timeout, span_count); end
    cmp++; if (eng_fb_addr !== 32'd0 || eng_x2 !== 16'd0 || eng_y !== 32'd0) begin bad++; $display("FAIL rstw_regs got fb=%h x2=%0d y=%0d want 0 0 0", eng_fb_addr, eng_x2, eng_y); end
    set_cmd(0, 16'd11, 16'd1, 16'd5, 32'd0, 32'd0, 32'd0);
    set_cmd(1, 16'd12, 16'd1, 16'd5, 32'd0, 32'd0, 32'd0);
    req_valid = 2'b11;
    tick;
    tick;
    nreset = 1'b1;
    tick;
    cmp++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rstw_first got %b want 01", req_ready); end
    tick;
    req_valid = 2'b00;
    cmp++; if (eng_start !== 1'b1 || eng_y !== 32'd11) begin bad++; $display("FAIL rstw_issue got start=%b y=%0d want 1 11", eng_start, eng_y); end
    tick;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
  endtask

  initial begin
    fb_base = 32'h1000_0000;
    zbuff_base = 32'h2000_0000;
    req_valid = '0;
    req_y = '0; req_x1 = '0; req_x2 = '0;
    req_z1 = '0; req_z2 = '0; req_slope = '0;
    eng_done = 1'b0;
    test_reset;
    test_single;
    test_reversed;
    test_zero_length;
    test_back_to_back;
    test_timeout;
    test_reset_wait;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
